// File: rtl/frame_buffer_dbl.sv
// Double-buffered pixel frame buffer: host writes the back bank, video reads the front bank,
// banks swap on a frame boundary, and a clear engine fills the back bank with a constant.
module frame_buffer_dbl #(
    parameter int DATA_W = 8,
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              frame_start,
    input  logic              swap_req,
    output logic              swap_pending,
    output logic              front_sel,
    input  logic              clear_req,
    input  logic [DATA_W-1:0] clear_value,
    output logic              clear_busy
);

    localparam int               DEPTH     = H_RES * V_RES;
    localparam int               MEM_AW    = $clog2(2 * DEPTH);
    localparam logic [ADDR_W:0]  DEPTH_W   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [DATA_W-1:0] mem [2*DEPTH];

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] clr_val_q, clr_val_d;
    logic              front_sel_q, front_sel_d;
    logic              swap_pending_q, swap_pending_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic              mem_we;
    logic [MEM_AW-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              do_swap;
    logic              wr_in_range;
    logic              rd_in_range;

    // Bank b lives at offset b*DEPTH; callers guarantee addr < DEPTH.
    function automatic logic [MEM_AW-1:0] bank_idx(input logic bank,
                                                   input logic [ADDR_W-1:0] addr);
        logic [ADDR_W:0] sum;
        sum = {1'b0, addr} + (bank ? DEPTH_W : {(ADDR_W + 1){1'b0}});
        return MEM_AW'(sum);
    endfunction

    assign clear_busy   = (state_q == ST_CLEAR);
    assign wr_ready     = ~clear_busy;
    assign front_sel    = front_sel_q;
    assign swap_pending = swap_pending_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

    // Clear FSM
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_val_d = clr_val_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                    clr_val_d = clear_value;
                end
            end
            default: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end
            end
        endcase
    end

    // The clear engine owns the write port while busy, so host writes are simply not accepted.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (clear_busy) begin
            mem_we    = 1'b1;
            mem_waddr = bank_idx(~front_sel_q, clr_cnt_q);
            mem_wdata = clr_val_q;
        end else if (wr_en && wr_in_range) begin
            mem_we    = 1'b1;
            mem_waddr = bank_idx(~front_sel_q, wr_addr);
            mem_wdata = wr_data;
        end
    end

    always_comb begin
        do_swap        = frame_start && (swap_pending_q || swap_req) && !clear_busy;
        front_sel_d    = front_sel_q ^ do_swap;
        swap_pending_d = swap_pending_q;
        if (do_swap) begin
            swap_pending_d = 1'b0;
        end else if (swap_req) begin
            swap_pending_d = 1'b1;
        end
    end

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (rd_en) begin
            rd_valid_d = 1'b1;
            rd_data_d  = rd_in_range ? mem[bank_idx(front_sel_q, rd_addr)] : '0;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            clr_cnt_q      <= '0;
            clr_val_q      <= '0;
            front_sel_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            clr_cnt_q      <= clr_cnt_d;
            clr_val_q      <= clr_val_d;
            front_sel_q    <= front_sel_d;
            swap_pending_q <= swap_pending_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_valid_d;
        end
    end

endmodule

// File: tb/tb_frame_buffer_dbl.sv
// Scoreboard bench for frame_buffer_dbl with an 8-word bank (4x2 pixels).
module tb_frame_buffer_dbl;

    localparam int DW    = 8;
    localparam int HR    = 4;
    localparam int VR    = 2;
    localparam int AW    = 4;
    localparam int DEPTH = HR * VR;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          frame_start;
    logic          swap_req;
    logic          swap_pending;
    logic          front_sel;
    logic          clear_req;
    logic [DW-1:0] clear_value;
    logic          clear_busy;

    logic [DW-1:0] model_mem [2*DEPTH];
    logic          model_front;
    logic [DW-1:0] exp_q [$];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    frame_buffer_dbl #(.DATA_W(DW), .H_RES(HR), .V_RES(VR), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .frame_start(frame_start), .swap_req(swap_req), .swap_pending(swap_pending),
        .front_sel(front_sel), .clear_req(clear_req), .clear_value(clear_value),
        .clear_busy(clear_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_addr = '0; wr_data = '0; rd_en = 0; rd_addr = '0;
        frame_start = 0; swap_req = 0; clear_req = 0; clear_value = '0;
    endtask

    // Back-to-back reads of the whole front bank against the model.
    task automatic read_all(input string tag);
        logic [DW-1:0] e;
        for (int i = 0; i < DEPTH; i++) begin
            rd_en = 1; rd_addr = AW'(i);
            exp_q.push_back(model_mem[(model_front ? DEPTH : 0) + i]);
            step();
            e = exp_q.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                errors++;
                $display("FAIL %s rd addr %0d got data %h valid %b exp data %h valid 1",
                         tag, i, rd_data, rd_valid, e);
            end else begin
                $display("%s rd addr %0d data %h", tag, i, rd_data);
            end
        end
        rd_en = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        repeat (3) @(posedge clk);
        #4 reset_n = 1;
        step();
        model_front = 0;
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
        checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL reset_front_sel got %b exp 0", front_sel); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
        checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL reset_clear_busy got %b exp 0", clear_busy); end
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL reset_swap_pending got %b exp 0", swap_pending); end
        $display("reset done");
    endtask

    task automatic test_write_swap_read();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1; wr_addr = AW'(i); wr_data = DW'(8'h11 + i);
            step();
            model_mem[(model_front ? 0 : DEPTH) + i] = DW'(8'h11 + i);
            $display("wr addr %0d data %h", i, DW'(8'h11 + i));
        end
        wr_en = 0;
        swap_req = 1;
        step();
        swap_req = 0;
        checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL pend_set got %b exp 1", swap_pending); end
        checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL pend_nofs got %b exp 0", front_sel); end
        frame_start = 1;
        step();
        frame_start = 0;
        model_front = 1;
        checks++; if (front_sel !== 1'b1) begin errors++; $display("FAIL swap1_front got %b exp 1", front_sel); end
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL swap1_pend got %b exp 0", swap_pending); end
        read_all("wsr");
        step();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", rd_valid); end
        checks++; if (rd_data !== 8'h18) begin errors++; $display("FAIL hold_data got %h exp 18", rd_data); end
    endtask

    task automatic test_clear_deferred_swap();
        int busy_cycles;
        clear_value = 8'hA5; clear_req = 1;
        step();
        clear_req = 0;
        checks++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL clr_busy got %b exp 1", clear_busy); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL clr_wr_ready got %b exp 0", wr_ready); end
        busy_cycles = 0;
        while (clear_busy === 1'b1 && busy_cycles < 20) begin
            wr_en = (busy_cycles == 2); wr_addr = 4'd3; wr_data = 8'h77;
            swap_req = (busy_cycles == 1);
            frame_start = (busy_cycles == 3);
            step();
            busy_cycles++;
        end
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) model_mem[(model_front ? 0 : DEPTH) + i] = 8'hA5;
        $display("clear busy cycles %0d", busy_cycles);
        checks++; if (busy_cycles != DEPTH) begin errors++; $display("FAIL clr_len got %0d exp %0d", busy_cycles, DEPTH); end
        checks++; if (front_sel !== 1'b1) begin errors++; $display("FAIL defer_front got %b exp 1", front_sel); end
        checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL defer_pend got %b exp 1", swap_pending); end
        frame_start = 1;
        step();
        frame_start = 0;
        model_front = 0;
        checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL defer_swap got %b exp 0", front_sel); end
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL defer_clr got %b exp 0", swap_pending); end
        read_all("clr");
    endtask

    task automatic test_out_of_range_and_swap_edge();
        logic [DW-1:0] e;
        wr_en = 1; wr_addr = 4'd9; wr_data = 8'hFF;
        rd_en = 1; rd_addr = 4'd9;
        exp_q.push_back(8'h00);
        step();
        idle_inputs();
        e = exp_q.pop_front();
        checks++;
        if (rd_data !== e || rd_valid !== 1'b1) begin
            errors++; $display("FAIL oor_read got %h/%b exp %h/1", rd_data, rd_valid, e);
        end else $display("oor rd addr 9 data %h", rd_data);
        // Read, write and swap on the same edge: read/write see the pre-swap banks.
        swap_req = 1; frame_start = 1;
        wr_en = 1; wr_addr = 4'd5; wr_data = 8'h55;
        rd_en = 1; rd_addr = 4'd0;
        exp_q.push_back(model_mem[(model_front ? DEPTH : 0)]);
        model_mem[(model_front ? 0 : DEPTH) + 5] = 8'h55;
        step();
        idle_inputs();
        model_front = ~model_front;
        e = exp_q.pop_front();
        checks++;
        if (rd_data !== e) begin errors++; $display("FAIL preswap_read got %h exp %h", rd_data, e); end
        else $display("preswap rd addr 0 data %h", rd_data);
        checks++; if (front_sel !== model_front) begin errors++; $display("FAIL edge_swap got %b exp %b", front_sel, model_front); end
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL edge_pend got %b exp 0", swap_pending); end
        read_all("oor");
    endtask

    task automatic test_reset_mid_clear();
        swap_req = 1; frame_start = 1;
        step();
        idle_inputs();
        model_front = ~model_front;
        checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL pre_rst_front got %b exp 0", front_sel); end
        clear_value = 8'hA5; clear_req = 1;
        step();
        clear_req = 0;
        repeat (3) step();
        for (int i = 0; i < 3; i++) model_mem[DEPTH + i] = 8'hA5;
        checks++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", clear_busy); end
        reset_n = 0;
        #1;
        checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", clear_busy); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", wr_ready); end
        #3 reset_n = 1;
        step();
        model_front = 0;
        $display("reset mid clear released");
        swap_req = 1; frame_start = 1;
        step();
        idle_inputs();
        model_front = 1;
        checks++; if (front_sel !== 1'b1) begin errors++; $display("FAIL post_rst_swap got %b exp 1", front_sel); end
        read_all("rmc");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_swap_read();
        test_clear_deferred_swap();
        test_out_of_range_and_swap_edge();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_buffer_dbl.md
# frame_buffer_dbl

Parametrised, single-clock, double-buffered pixel frame buffer for the HDMI path. It holds two banks of H_RES×V_RES pixels of DATA_W bits. The drawing side writes only the back bank; the video scan-out side reads only the front bank. Banks swap only at a frame boundary, and a built-in clear engine fills the back bank with a constant.

## Interface
Parameters:
- DATA_W, 8: pixel width in bits
- H_RES, 640: pixels per line
- V_RES, 480: lines per frame; DEPTH = H_RES*V_RES words per bank
- ADDR_W, 19: address width; must satisfy 2^ADDR_W ≥ DEPTH

Ports:
- clk  in  1  single clock for all logic
- reset_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  write strobe (back bank)
- wr_addr  in  ADDR_W  write pixel address
- wr_data  in  DATA_W  write pixel
- wr_ready  out  1  high when host writes are accepted
- rd_en  in  1  read strobe (front bank)
- rd_addr  in  ADDR_W  read pixel address
- rd_data  out  DATA_W  registered read pixel
- rd_valid  out  1  rd_data updated this cycle
- frame_start  in  1  one-cycle pulse from video timing at start of frame
- swap_req  in  1  one-cycle pulse requesting a bank swap
- swap_pending  out  1  swap requested, not yet applied
- front_sel  out  1  bank currently scanned out; back bank = ~front_sel
- clear_req  in  1  one-cycle pulse to start clearing the back bank
- clear_value  in  DATA_W  fill value, sampled with clear_req
- clear_busy  out  1  clear engine active

## Operation
- Storage: 2*DEPTH words, bank b at offset b*DEPTH. Memory contents are not reset.
- Reset values: front_sel=0, swap_pending=0, clear_busy=0, wr_ready=1, rd_data=0, rd_valid=0, FSM=IDLE, clear counter=0.
- Host write: when wr_en && wr_ready && wr_addr<DEPTH, mem[back][wr_addr] ← wr_data. If wr_addr≥DEPTH, the write is dropped silently.
- Read: on rd_en, rd_data ← mem[front][rd_addr] (rd_data ← 0 if rd_addr≥DEPTH) and rd_valid←1. Without rd_en, rd_valid←0 and rd_data holds its value.
- Read/write conflicts cannot occur because reads and writes always address different banks.
- Clear FSM, states IDLE and CLEAR:
  - IDLE→CLEAR on clear_req. Latch clear_value, counter←0, clear_busy←1.
  - CLEAR: each cycle write the latched value to mem[back][counter], then counter++.
  - CLEAR→IDLE after writing address DEPTH-1; clear_busy←0.
  - clear_req during CLEAR is ignored.
- wr_ready = ~clear_busy (combinational). Host writes during CLEAR are ignored, not queued.
- Swap:
  - swap_req sets swap_pending.
  - On a cycle with frame_start && (swap_pending || swap_req) && !clear_busy: front_sel toggles and swap_pending←0.
  - While clear_busy, a frame_start leaves the swap pending; it is applied at the first frame_start after the clear finishes.
  - Repeated swap_req while pending is absorbed: one swap per pending request.
- Reset asserted mid-clear aborts the clear immediately; the partially cleared bank is left as is.

## Timing
- Read latency 1: rd_en sampled at edge t; rd_data and rd_valid are valid after edge t.
- A read issued in the same cycle as a swap uses the pre-swap front_sel. front_sel changes after the swap edge.
- Clear: clear_req sampled at edge t; clear_busy=1 from after t. Address k is written at edge t+1+k. clear_busy=0 after edge t+DEPTH. Busy lasts exactly DEPTH cycles.
- A host write at the same edge as clear_req is accepted (wr_ready is still 1). Clear then overwrites it.
- A write in the same cycle as a swap goes to the pre-swap back bank.
- Throughput: one host write and one read per cycle, sustained.

## Test plan
Parameters DATA_W=8, H_RES=4, V_RES=2 (DEPTH=8).
- Reset, then idle: rd_data=0, rd_valid=0, front_sel=0, wr_ready=1, clear_busy=0, swap_pending=0.
- Write 0x11..0x18 to addresses 0..7, pulse swap_req then frame_start, read addresses 0..7 → one cycle after each rd_en, rd_data=0x11..0x18 with rd_valid=1; front_sel=1.
- clear_req with clear_value=0xA5: clear_busy high exactly 8 cycles; wr_en=1 to addr 3 with 0x77 during clear is dropped. After a swap, all 8 reads return 0xA5.
- swap_req, then frame_start while clear_busy=1 → front_sel unchanged, swap_pending=1. Next frame_start after clear finishes → front_sel toggles, swap_pending=0.
- wr_addr=9 with 0xFF → no bank changes. rd_addr=9 → rd_data=0 one cycle later.
- reset_n low at clear cycle 3 → clear_busy=0 and wr_ready=1 immediately. Addresses 0..2 hold 0xA5 and addresses 3..7 hold their old data.
